// File: rtl/fifo_drain_pkg.sv
// Shared types and default constants for the flushable-FIFO drain sequencer.
package fifo_drain_pkg;

  localparam int unsigned RD_WIDTH      = 32;
  localparam int unsigned OUT_DEPTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF   = 16;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned TIMER_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  // One output-queue entry: flush marks words produced by a flush (may be zero padded).
  typedef struct packed {
    logic                flush;
    logic [RD_WIDTH-1:0] data;
  } q_entry_t;

endpackage

// File: rtl/drain_out_queue.sv
// Small synchronous FIFO of queue entries with simultaneous push/pop and a
// combinational head.
module drain_out_queue
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DEPTH = OUT_DEPTH_DEF,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  q_entry_t      i_push_entry,
  input  logic          i_pop,
  output q_entry_t      o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  q_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full queue is accepted only when the head leaves this cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Consumer-side sequencer for the 4-in/32-out flushable FIFO: reads full words,
// flushes idle partial data on timeout or software request, and queues results.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_data_avail_i,
  input  logic                fifo_empty_i,
  input  logic                fifo_flush_done_i,
  input  logic [RD_WIDTH-1:0] fifo_rd_data_i,
  output logic                fifo_rd_o,
  output logic                fifo_flush_o,
  input  logic                force_flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [RD_WIDTH-1:0] out_data_o,
  output logic                out_flush_o,
  output logic                flush_cmpl_o,
  output logic [CNT_W-1:0]    word_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  localparam int unsigned QCW = $clog2(OUT_DEPTH + 1);

  drain_state_t       r_state;
  drain_state_t       w_next_state;
  logic               r_pending;
  logic               w_pending_next;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_next;
  logic               r_flush;
  logic               r_flush_cmpl;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  q_entry_t           w_push_entry;
  q_entry_t           w_head;
  logic [QCW-1:0]     w_count;
  logic               w_q_full;
  logic               w_q_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_rd;
  logic               w_flush_push;
  logic               w_start;
  logic               w_drain_done;
  logic               w_idle_partial;
  logic               w_timeout;
  logic               w_force_ok;

  drain_out_queue #(
    .DEPTH (OUT_DEPTH),
    .CW    (QCW)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_q_full),
    .o_empty      (w_q_empty)
  );

  // Read/flush capture path into the output queue.
  assign w_pop        = !w_q_empty && out_ready_i;
  assign w_rd         = !rst && (r_state == IDLE) && fifo_data_avail_i && !r_pending
                        && (!w_q_full || w_pop);
  assign w_flush_push = (r_state == FLUSH) && !fifo_empty_i;
  assign w_push       = w_rd || w_flush_push;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.flush = (r_state == FLUSH);
    w_push_entry.data  = fifo_rd_data_i;
  end

  // Idle-partial timer and flush request bookkeeping.
  assign w_idle_partial = (r_state == IDLE) && !fifo_empty_i && !fifo_data_avail_i && !r_pending;
  assign w_timeout      = w_idle_partial && (r_timer == TIMER_W'(TIMEOUT - 1));
  assign w_force_ok     = force_flush_i && !((r_state == IDLE) && fifo_empty_i);

  always_comb begin
    w_timer_next   = '0;
    w_pending_next = r_pending;
    if (w_idle_partial && !w_timeout) begin
      w_timer_next = r_timer + TIMER_W'(1);
    end
    // A request arriving on the flush start cycle is served by that flush.
    if (w_start) begin
      w_pending_next = 1'b0;
    end else if (w_force_ok || w_timeout) begin
      w_pending_next = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_drain_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pending && w_q_empty && !fifo_empty_i) begin
          w_next_state = FLUSH;
          w_start      = 1'b1;
        end
      end
      FLUSH: begin
        if (fifo_flush_done_i) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_q_empty || ((w_count == QCW'(1)) && w_pop)) begin
          w_next_state = IDLE;
          w_drain_done = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= 1'b0;
      r_timer      <= '0;
      r_flush      <= 1'b0;
      r_flush_cmpl <= 1'b0;
      r_word_cnt   <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pending    <= w_pending_next;
      r_timer      <= w_timer_next;
      r_flush      <= (w_next_state == FLUSH);
      r_flush_cmpl <= w_drain_done;
      if (w_pop && (r_word_cnt != '1)) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (w_drain_done && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign fifo_rd_o    = w_rd;
  assign fifo_flush_o = r_flush;
  assign out_valid_o  = !w_q_empty;
  assign out_data_o   = w_q_empty ? '0 : w_head.data;
  assign out_flush_o  = !w_q_empty && w_head.flush;
  assign flush_cmpl_o = r_flush_cmpl;
  assign word_cnt_o   = r_word_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl with a nibble-level model of the flushable FIFO.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DEPTH   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                fifo_data_avail;
  logic                fifo_empty;
  logic                fifo_flush_done;
  logic [RD_WIDTH-1:0] fifo_rd_data;
  logic                fifo_rd;
  logic                fifo_flush;
  logic                force_flush;
  logic                out_valid;
  logic                out_ready;
  logic [RD_WIDTH-1:0] out_data;
  logic                out_flush;
  logic                flush_cmpl;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .OUT_DEPTH (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_data_avail_i (fifo_data_avail),
    .fifo_empty_i      (fifo_empty),
    .fifo_flush_done_i (fifo_flush_done),
    .fifo_rd_data_i    (fifo_rd_data),
    .fifo_rd_o         (fifo_rd),
    .fifo_flush_o      (fifo_flush),
    .force_flush_i     (force_flush),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_data_o        (out_data),
    .out_flush_o       (out_flush),
    .flush_cmpl_o      (flush_cmpl),
    .word_cnt_o        (word_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: nibble store, LSB-first packing, flush pops up to one word per cycle.
  logic [3:0] m_mem [0:4095];
  int         m_wp = 0;
  int         m_rp = 0;
  int         m_lvl;
  logic       wr_en = 1'b0;
  logic [3:0] wr_nib = 4'h0;
  logic       hold_done = 1'b0;

  always_comb begin
    m_lvl           = m_wp - m_rp;
    fifo_data_avail = (m_lvl >= 8);
    fifo_empty      = (m_lvl == 0);
    fifo_rd_data    = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < m_lvl) fifo_rd_data[i*4 +: 4] = m_mem[(m_rp + i) & 4095];
    end
    fifo_flush_done = fifo_flush && fifo_empty && !hold_done;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_rp <= m_wp;
    end else begin
      if (wr_en) begin
        m_mem[m_wp & 4095] <= wr_nib;
        m_wp <= m_wp + 1;
      end
      if (fifo_rd) m_rp <= m_rp + 8;
      else if (fifo_flush && m_lvl > 0) m_rp <= m_rp + ((m_lvl > 8) ? 8 : m_lvl);
    end
  end

  q_entry_t sb[$];
  int       n_flush_rise = 0;
  int       n_cmpl = 0;
  logic     prev_flush = 1'b0;

  task automatic sb_push(input logic fl, input logic [31:0] d);
    q_entry_t e;
    e.flush = fl;
    e.data  = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    q_entry_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra_word", 64'({out_flush, out_data}), 64'(sb.size()));
        end else begin
          e = sb.pop_front();
          check_eq("out_data", 64'(out_data), 64'(e.data));
          check_eq("out_flush", 64'(out_flush), 64'(e.flush));
        end
      end
      if (fifo_flush && !prev_flush) begin
        n_flush_rise++;
        check_eq("flush_entry_q_empty", 64'(out_valid), 64'(0));
      end
      if (flush_cmpl) n_cmpl++;
    end
    prev_flush = fifo_flush;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_nib(input logic [3:0] v);
    wr_en  = 1'b1;
    wr_nib = v;
    tick(1);
    wr_en  = 1'b0;
  endtask

  task automatic pulse_force();
    force_flush = 1'b1;
    tick(1);
    force_flush = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget, input string tag);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic wait_cmpl(input int budget, input string tag);
    int target = n_cmpl + 1;
    int k = 0;
    while (n_cmpl < target && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 64'(n_cmpl), 64'(target));
  endtask

  task automatic wait_flush_rise(input int budget, input string tag);
    int k = 0;
    while (!fifo_flush && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 64'(fifo_flush), 64'(1));
  endtask

  initial begin
    logic [31:0] wd;
    logic [3:0]  v;
    int r0, c0;

    rst = 1'b0; force_flush = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_flush", 64'(fifo_flush), 64'(0));
    check_eq("rst_rd", 64'(fifo_rd), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_cnts", 64'({word_cnt, flush_cnt, flush_cmpl}), 64'(0));
    tick(3);
    rst = 1'b0;
    tick(2);

    // Full words only: eight reads, no flush.
    out_ready = 1'b1;
    r0 = n_flush_rise;
    for (int w = 0; w < 8; w++) begin
      wd = '0;
      for (int k = 0; k < 8; k++) wd[k*4 +: 4] = 4'(w * 3 + k * 5 + 1);
      sb_push(1'b0, wd);
      for (int k = 0; k < 8; k++) write_nib(4'(w * 3 + k * 5 + 1));
    end
    wait_sb_empty(60, "t1_drain");
    tick(2);
    check_eq("t1_word_cnt", 64'(word_cnt), 64'(8));
    check_eq("t1_no_flush", 64'(n_flush_rise - r0), 64'(0));

    // Partial data times out into one padded flush word.
    r0 = n_flush_rise; c0 = n_cmpl;
    sb_push(1'b1, 32'h0000_0321);
    write_nib(4'h1); write_nib(4'h2); write_nib(4'h3);
    wait_cmpl(100, "t2_cmpl");
    tick(5);
    check_eq("t2_cmpl_once", 64'(n_cmpl - c0), 64'(1));
    check_eq("t2_flush_once", 64'(n_flush_rise - r0), 64'(1));
    check_eq("t2_flush_cnt", 64'(flush_cnt), 64'(1));
    check_eq("t2_sb_empty", 64'(sb.size()), 64'(0));

    // Forced flush waits until the queued read words drain.
    out_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wd = '0;
      for (int k = 0; k < 8; k++) wd[k*4 +: 4] = 4'(w * 8 + k + 10);
      sb_push(1'b0, wd);
    end
    sb_push(1'b1, 32'h0000_DCBA);
    for (int i = 0; i < 20; i++) write_nib(4'(i + 10));
    pulse_force();
    tick(10);
    check_eq("t3_queued_valid", 64'(out_valid), 64'(1));
    check_eq("t3_no_flush_while_queued", 64'(fifo_flush), 64'(0));
    check_eq("t3_word_cnt_hold", 64'(word_cnt), 64'(9));
    out_ready = 1'b1;
    wait_cmpl(80, "t3_cmpl");
    tick(2);
    check_eq("t3_flush_cnt", 64'(flush_cnt), 64'(2));
    check_eq("t3_word_cnt", 64'(word_cnt), 64'(12));

    // Force during FLUSH yields exactly one further flush.
    r0 = n_flush_rise;
    hold_done = 1'b1;
    sb_push(1'b1, 32'h0000_0765);
    write_nib(4'h5); write_nib(4'h6); write_nib(4'h7);
    pulse_force();
    wait_flush_rise(20, "t4_flush_seen");
    tick(1);
    pulse_force();
    hold_done = 1'b0;
    wait_cmpl(40, "t4_cmpl1");
    tick(5);
    check_eq("t4_pending_waits_data", 64'(n_flush_rise - r0), 64'(1));
    sb_push(1'b1, 32'h0000_0009);
    write_nib(4'h9);
    wait_cmpl(40, "t4_cmpl2");
    tick(30);
    check_eq("t4_one_extra_flush", 64'(n_flush_rise - r0), 64'(2));
    check_eq("t4_flush_cnt", 64'(flush_cnt), 64'(4));

    // Force with an empty FIFO is dropped.
    r0 = n_flush_rise;
    pulse_force();
    tick(30);
    check_eq("t4_empty_force_no_flush", 64'(n_flush_rise - r0), 64'(0));
    check_eq("t4_empty_force_cnt", 64'(flush_cnt), 64'(4));
    check_eq("t4_word_cnt", 64'(word_cnt), 64'(14));

    // Reset in the middle of a flush.
    out_ready = 1'b0;
    hold_done = 1'b1;
    write_nib(4'h1); write_nib(4'h1); write_nib(4'h1);
    pulse_force();
    wait_flush_rise(20, "t5_flush_seen");
    tick(2);
    check_eq("t5_pre_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_flush", 64'(fifo_flush), 64'(0));
    check_eq("t5_rst_valid", 64'(out_valid), 64'(0));
    check_eq("t5_rst_word_cnt", 64'(word_cnt), 64'(0));
    check_eq("t5_rst_flush_cnt", 64'(flush_cnt), 64'(0));
    tick(2);
    rst = 1'b0;
    hold_done = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    r0 = n_flush_rise;
    tick(2);
    check_eq("t5_idle_after_rst", 64'(fifo_flush), 64'(0));
    sb_push(1'b0, 32'h8765_4321);
    for (int k = 0; k < 8; k++) write_nib(4'(k + 1));
    wait_sb_empty(30, "t5_read_after_rst");
    tick(2);
    check_eq("t5_word_cnt", 64'(word_cnt), 64'(1));
    check_eq("t5_no_flush", 64'(n_flush_rise - r0), 64'(0));

    // Saturation of both counters at 4'hF.
    for (int w = 0; w < 15; w++) begin
      wd = '0;
      for (int k = 0; k < 8; k++) wd[k*4 +: 4] = 4'(w + k * 7);
      sb_push(1'b0, wd);
      for (int k = 0; k < 8; k++) write_nib(4'(w + k * 7));
    end
    wait_sb_empty(80, "t6_drain");
    tick(2);
    check_eq("t6_word_sat", 64'(word_cnt), 64'(15));
    for (int f = 0; f < 16; f++) begin
      v = 4'(f + 3);
      sb_push(1'b1, 32'(v));
      write_nib(v);
      pulse_force();
      wait_cmpl(40, "t6_flush_cmpl");
      tick(1);
    end
    check_eq("t6_flush_sat", 64'(flush_cnt), 64'(15));
    check_eq("t6_word_sat_hold", 64'(word_cnt), 64'(15));
    check_eq("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
